// File: rtl/grip_controller.sv
// grip_controller: multi-finger servo gripper FSM with pressure-based contact and PWM drive.
// Optional macro GRIP_SLIP_DETECT_EN re-tightens fingers that lose contact while holding.
module grip_controller #(
  parameter int N_FINGERS = 3,
  parameter int PRESS_W   = 8,
  parameter int DIST_W    = 8,
  parameter int DIST_MIN  = 5,
  parameter int DIST_MAX  = 10,
  parameter int POS_MAX   = 200,
  parameter int STEP_DIV  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_command,
  input  logic [DIST_W-1:0]              i_distance,
  input  logic [N_FINGERS*PRESS_W-1:0]   i_press,
  input  logic [PRESS_W-1:0]             i_press_limit,
  output logic [N_FINGERS-1:0]           o_servo,
  output logic [2:0]                     o_state,
  output logic                           o_gripped,
  output logic                           o_fault
);
  typedef enum logic [2:0] {IDLE = 3'd0, CLOSING = 3'd1, HOLD = 3'd2, OPENING = 3'd3, FAULT = 3'd4} state_t;
  localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  state_t state_q, state_d;
  logic [N_FINGERS-1:0][7:0] pos_q, pos_d;
  logic [PW-1:0] presc_q;
  logic [7:0] pwm_q;
  logic [N_FINGERS-1:0] servo_q, contact, at_max, inc, dec;
  logic gripped_q, fault_q, step_tick, dist_ok, all_contact, stall, all_zero, grow, shrink;
  assign step_tick   = presc_q == PW'(STEP_DIV - 1);
  assign dist_ok     = i_distance >= DIST_W'(DIST_MIN) && i_distance <= DIST_W'(DIST_MAX);
  assign all_contact = &contact;
  assign stall       = |(~contact & at_max);
  assign all_zero    = pos_q == '0;
  for (genvar k = 0; k < N_FINGERS; k++) begin : g_finger
    assign contact[k] = i_press[k*PRESS_W +: PRESS_W] >= i_press_limit;
    assign at_max[k]  = pos_q[k] == 8'(POS_MAX);
    assign inc[k]     = step_tick & ~contact[k] & ~at_max[k];
    assign dec[k]     = step_tick & (pos_q[k] != 8'd0);
  end
`ifdef GRIP_SLIP_DETECT_EN
  assign grow = state_q == CLOSING || state_q == HOLD;
`else
  assign grow = state_q == CLOSING;
`endif
  assign shrink = state_q == OPENING;
  always_comb begin
    state_d = state_q;
    for (int k = 0; k < N_FINGERS; k++)
      pos_d[k] = state_q == IDLE ? 8'd0 : pos_q[k] + 8'(grow & inc[k]) - 8'(shrink & dec[k]);
    case (state_q)
      IDLE:    state_d = i_command && dist_ok ? CLOSING : IDLE;
      CLOSING: state_d = !i_command ? OPENING : all_contact ? HOLD : stall ? FAULT : CLOSING;
`ifdef GRIP_SLIP_DETECT_EN
      HOLD:    state_d = !i_command ? OPENING : stall ? FAULT : HOLD;
`else
      HOLD:    state_d = !i_command ? OPENING : HOLD;
`endif
      OPENING: state_d = all_zero ? IDLE : OPENING;
      FAULT:   state_d = !i_command ? OPENING : FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      presc_q   <= '0;
      pwm_q     <= '0;
      servo_q   <= '0;
      gripped_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      presc_q   <= step_tick ? '0 : presc_q + PW'(1);
      pwm_q     <= pwm_q + 8'd1;
      for (int k = 0; k < N_FINGERS; k++) servo_q[k] <= pwm_q < pos_q[k];
      gripped_q <= state_d == HOLD;
      fault_q   <= state_d == FAULT;
    end
  end
  assign o_state   = state_q;
  assign o_servo   = servo_q;
  assign o_gripped = gripped_q;
  assign o_fault   = fault_q;
endmodule

// File: doc/grip_controller.md
GRIP_CONTROLLER -- requirements
Module: grip_controller

Interface
REQ-001 SHALL have parameter N_FINGERS, default 3, number of finger servo channels (1..8).
REQ-002 SHALL have parameter PRESS_W, default 8, width of each strain-gauge pressure sample.
REQ-003 SHALL have parameter DIST_W, default 8, width of the distance input in cm.
REQ-004 SHALL have parameters DIST_MIN, default 5, and DIST_MAX, default 10, the inclusive valid grip window in cm.
REQ-005 SHALL have parameter POS_MAX, default 200, the fully-closed servo position (8-bit, at most 255).
REQ-006 SHALL have parameter STEP_DIV, default 4, the number of clk cycles per position step (at least 1).
REQ-007 SHALL have port clk, input, 1 bit, system clock, with all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port i_command, input, 1 bit: 1 = lift/grip, 0 = drop/release.
REQ-010 SHALL have port i_distance, input, DIST_W bits, object distance in cm.
REQ-011 SHALL have port i_press, input, N_FINGERS*PRESS_W bits, per-finger pressure; finger k occupies bits [k*PRESS_W +: PRESS_W].
REQ-012 SHALL have port i_press_limit, input, PRESS_W bits, the grip pressure threshold.
REQ-013 SHALL have port o_servo, output, N_FINGERS bits, per-finger PWM drive.
REQ-014 SHALL have port o_state, output, 3 bits, FSM state: IDLE=0, CLOSING=1, HOLD=2, OPENING=3, FAULT=4.
REQ-015 SHALL have port o_gripped, output, 1 bit, high exactly when the state is HOLD.
REQ-016 SHALL have port o_fault, output, 1 bit, high exactly when the state is FAULT.

Function
REQ-017 SHALL treat the distance as valid iff DIST_MIN <= i_distance <= DIST_MAX, compared unsigned.
REQ-018 SHALL keep an 8-bit position register pos[k] per finger; 0 = fully open.
REQ-019 SHALL run a free-running prescaler 0..STEP_DIV-1 and assert step_tick for one cycle when it reaches STEP_DIV-1, then wrap to 0.
REQ-020 SHALL consider finger k "contact" when i_press[k] >= i_press_limit, compared unsigned.
REQ-021 IDLE: SHALL hold all pos at 0 and go to CLOSING on the next edge when i_command=1 and the distance is valid.
REQ-022 CLOSING: on each step_tick SHALL increment pos[k] by 1 for every finger that is not in contact and has pos[k] < POS_MAX; fingers in contact SHALL hold.
REQ-023 CLOSING: SHALL go to HOLD when all fingers are in contact, including on the first cycle in the state.
REQ-024 CLOSING: SHALL go to FAULT when any finger without contact has pos[k] == POS_MAX.
REQ-025 CLOSING: if i_command=0 SHALL go to OPENING, with priority over HOLD and FAULT.
REQ-026 CLOSING: SHALL ignore distance changes after entry.
REQ-027 HOLD: SHALL hold all pos and go to OPENING when i_command=0.
REQ-028 OPENING: on each step_tick SHALL decrement every nonzero pos[k] by 1.
REQ-029 OPENING: SHALL go to IDLE when all pos are 0, and SHALL ignore i_command=1 until IDLE is reached.
REQ-030 FAULT: SHALL hold all pos and go to OPENING only when i_command=0.
REQ-031 SHALL run a free-running 8-bit PWM counter that wraps 255->0.
REQ-032 SHALL drive o_servo[k] from a register set to (pwm_cnt < pos[k]): pos=0 gives constant low, pos=N gives N high cycles per 256.
REQ-033 SHALL register o_state, o_gripped and o_fault, updating them on the same edge as the state change.

Reset
REQ-034 On rst_n=0 SHALL immediately, without waiting for clk, set state=IDLE, all pos=0, prescaler=0, pwm_cnt=0 and o_servo, o_gripped and o_fault to 0; this applies in any state, including mid-CLOSING.
REQ-035 SHALL release reset on the first clk edge after rst_n goes high.

Configuration
REQ-036 SHALL provide slip re-tightening when macro GRIP_SLIP_DETECT_EN is defined: in HOLD, on step_tick, pos[k] increments for every finger that has lost contact.
REQ-037 With GRIP_SLIP_DETECT_EN defined, HOLD SHALL go to FAULT when a finger without contact reaches POS_MAX, and o_gripped SHALL stay high during re-tightening.
REQ-038 Without GRIP_SLIP_DETECT_EN, HOLD SHALL ignore i_press entirely.

Verification
REQ-039 Bench SHALL check reset: rst_n=0 mid-CLOSING with pos=37 -> o_state=0, pos=0 and o_servo=0 immediately, without a clk edge.
REQ-040 Bench SHALL check a normal grip: command=1, distance=8, limit=100, all press=0, with press raised to 120 when pos reaches 50 -> HOLD, o_gripped=1, pos=50 on every finger.
REQ-041 Bench SHALL check the distance gate: command=1, distance=3 and then 11 -> stays in IDLE; distance=5 and distance=10 -> CLOSING on the next edge.
REQ-042 Bench SHALL check an empty grip: command=1, distance=8, press=0 throughout -> FAULT after 200*4 cycles, o_fault=1; command=0 -> OPENING, then IDLE after pos reaches 0.
REQ-043 Bench SHALL check staggered contact: finger 0 press=120 at pos=20, fingers 1-2 at pos=60 -> final pos {20,60,60}, HOLD.
REQ-044 Bench SHALL check slip with GRIP_SLIP_DETECT_EN defined: in HOLD, finger 1 press drops to 90 -> pos[1] increments each tick until press>=100, state stays HOLD; without the macro, pos stays unchanged.
